// File: rtl/debug_response_encoder.sv
// ---------------------------------------------------------------------------
// debug_response_encoder
//
// Serialises one debug response request into a byte frame for a serial
// transmitter:  header (command code), 1/2/4 data bytes LSB first, and an
// optional XOR checksum byte. Data byte count comes from code[7:6]:
// 00 -> 1, 01 -> 2, 10/11 -> 4.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high
//   req_valid  request present
//   req_code   [7:6] size selector, [5:0] selector echoed to the host
//   req_data   32-bit response word
//   req_ready  request can be accepted (IDLE only)
//   tx_data    byte toward the transmitter (8'h00 when idle)
//   tx_valid   tx_data is valid
//   tx_ready   transmitter accepts the byte this cycle
//   busy       a frame is in progress
// ---------------------------------------------------------------------------
module debug_response_encoder #(
    parameter int CHECKSUM_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [7:0]  req_code,
    input  logic [31:0] req_data,
    output logic        req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    localparam bit HAS_CSUM = (CHECKSUM_EN != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        CSUM   = 2'd3
    } state_t;

    state_t      state;
    // Only the size field of the code is kept: the full header byte is
    // captured straight into tx_data at accept and held there until sent.
    logic [1:0]  size_q;
    logic [31:0] data_q;
    logic [1:0]  idx;
    logic [7:0]  csum;

    logic        xfer;
    logic [1:0]  last_idx;
    logic [1:0]  idx_next;
    logic [7:0]  csum_next;
    logic [7:0]  next_byte;

    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        xfer      = tx_valid && tx_ready;
        csum_next = csum ^ tx_data;
        idx_next  = idx + 2'd1;
        next_byte = byte_sel(data_q, idx_next);
        last_idx  = 2'd3;
        case (size_q)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;   // 10, and reserved 11
        endcase
    end

    // All outputs are registered and updated together with the state, so
    // tx_data is naturally held while the transmitter stalls.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            size_q    <= 2'b00;
            data_q    <= 32'h0;
            idx       <= 2'd0;
            csum      <= 8'h00;
            req_ready <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q    <= req_code[7:6];
                        data_q    <= req_data;
                        idx       <= 2'd0;
                        csum      <= 8'h00;
                        tx_data   <= req_code;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= HEADER;
                    end else begin
                        // First edge after reset release lands here.
                        req_ready <= 1'b1;
                    end
                end

                HEADER: begin
                    if (xfer) begin
                        csum    <= csum_next;
                        idx     <= 2'd0;
                        tx_data <= data_q[7:0];
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if (idx == last_idx) begin
                            if (HAS_CSUM) begin
                                // csum_next already folds in this last data byte.
                                tx_data <= csum_next;
                                state   <= CSUM;
                            end else begin
                                idx       <= 2'd0;
                                tx_data   <= 8'h00;
                                tx_valid  <= 1'b0;
                                busy      <= 1'b0;
                                req_ready <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            idx     <= idx_next;
                            tx_data <= next_byte;
                        end
                    end
                end

                CSUM: begin
                    if (xfer) begin
                        idx       <= 2'd0;
                        tx_data   <= 8'h00;
                        tx_valid  <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_response_encoder.md
DEBUG_RESPONSE_ENCODER -- requirements
Module: debug_response_encoder

Interface
REQ-001 The block SHALL have parameter CHECKSUM_EN, default 1, which appends an XOR checksum byte to every frame when set to 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; SHALL force the reset state immediately, independent of clk.
REQ-004 req_valid  input  1  a debug response request is present.
REQ-005 req_code  input  8  command code; [7:6] is the size selector, [5:0] is the selector echoed to the host.
REQ-006 req_data  input  32  response word (pipeline probe value).
REQ-007 req_ready  output  1  the block can accept a request.
REQ-008 tx_data  output  8  byte toward the serial transmitter.
REQ-009 tx_valid  output  1  tx_data is valid.
REQ-010 tx_ready  input  1  the transmitter accepts the byte this cycle.
REQ-011 busy  output  1  a frame is in progress (state not IDLE).

Function
REQ-012 The block SHALL implement states IDLE, HEADER, DATA and CSUM.
REQ-013 Request accept: req_valid && req_ready on a clock edge; req_ready SHALL equal 1 only in IDLE.
REQ-014 On accept, the block SHALL register req_code and req_data, clear the checksum, and go to HEADER; tx_valid SHALL rise in the following cycle (1-cycle latency).
REQ-015 Byte transfer: tx_valid && tx_ready on a clock edge; while tx_valid=1 and tx_ready=0, tx_data SHALL hold stable and tx_valid SHALL stay 1.
REQ-016 HEADER SHALL present tx_data = registered req_code; on transfer, the block SHALL go to DATA with byte index 0.
REQ-017 Data byte count N SHALL follow code[7:6]: 00 -> 1, 01 -> 2, 10 -> 4, 11 -> 4 (reserved, treated as 4).
REQ-018 DATA SHALL send req_data LSB first: byte i = req_data[8i+7:8i]; the index SHALL increment only on transfer.
REQ-019 After transfer of byte N-1, the block SHALL go to CSUM if CHECKSUM_EN=1, else to IDLE.
REQ-020 The checksum SHALL be the 8-bit XOR of the header and all data bytes transferred in the frame; CSUM SHALL present it, and on transfer the block SHALL go to IDLE.
REQ-021 req_ready SHALL be 1 in the cycle after the final transfer; back-to-back frames therefore have exactly one idle cycle between the last byte and the next header-valid cycle.
REQ-022 tx_valid SHALL be 0 in IDLE; tx_data in IDLE SHALL be 8'h00.
REQ-023 Changes to req_code or req_data after accept SHALL NOT affect the frame in progress.
REQ-024 req_valid asserted while busy SHALL be ignored (not accepted) until IDLE.
REQ-025 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-026 While reset=1: state = IDLE, req_ready = 0, tx_valid = 0, tx_data = 8'h00, busy = 0, index = 0, checksum = 0, registered code and data = 0.
REQ-027 After reset deasserts, req_ready SHALL be 1 from the first clock edge onward.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no further bytes; the next accepted request SHALL start a fresh frame with its header.

Verification
REQ-029 Code 8'h21, data 32'hDEADBEEF, tx_ready held 1, CHECKSUM_EN=1 -> bytes 21, EF, 21^EF = CE; busy for 3 cycles.
REQ-030 Code 8'h81, data 32'h12345678, tx_ready=1 -> bytes 81, 78, 56, 34, 12, checksum 81^78^56^34^12 = 89.
REQ-031 Same as REQ-030 with tx_ready toggling 1/0 each cycle -> identical byte sequence; tx_data stable during every stall; no byte duplicated or dropped.
REQ-032 Code 8'hC3 with CHECKSUM_EN=0 -> header plus 4 data bytes and no checksum byte; req_ready high the cycle after the last transfer.
REQ-033 Assert reset after the second data byte of REQ-030, then request code 8'h42, data 32'h0000ABCD -> tx_valid drops immediately; new frame is 42, CD, AB, checksum 42^CD^AB = 24.
REQ-034 req_valid held high with changing data during a frame -> only the request accepted in IDLE is sent; the next request is accepted only after the frame completes.
